// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, fixed 34-cycle latency, single-cycle register-file write-back.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic            rf_en,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata
);

    // state | meaning
    // IDLE  | waiting for an issue
    // CALC  | one multiply/divide iteration per cycle, 32 cycles
    // FIX   | sign correction, special cases, register result
    // DONE  | write-back pulse
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_f3;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_hi, r_lo, r_b, r_rs1, r_wdata;
    logic              r_neg, r_neg_r, r_div0, r_ovf;

    logic              w_issue, w_sa, w_sb;
    logic [XLEN-1:0]   w_mag_a, w_mag_b;
    logic [XLEN:0]     w_sum, w_shift;
    logic              w_ge;
    logic [XLEN-1:0]   w_sub;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_result;

    assign w_issue = (r_state == IDLE) && start && !kill;
    assign w_sa    = rs1_data[XLEN-1] & (funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11));
    assign w_sb    = rs2_data[XLEN-1] & (funct3[2] ? ~funct3[0] : ~funct3[1]);
    assign w_mag_a = w_sa ? -rs1_data : rs1_data;
    assign w_mag_b = w_sb ? -rs2_data : rs2_data;

    // Multiply: {r_hi, r_lo} is the product/multiplier shift pair.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_ge    = w_shift >= {1'b0, r_b};
    assign w_sub   = w_shift[XLEN-1:0] - r_b;

    assign w_prod  = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};

    always_comb begin
        w_result = '0;
        if (!r_f3[2])
            w_result = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        else if (r_div0)
            w_result = r_f3[1] ? r_rs1 : '1;
        else if (r_ovf)
            w_result = r_f3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        else if (r_f3[1])
            w_result = r_neg_r ? -r_hi : r_hi;
        else
            w_result = r_neg ? -r_lo : r_lo;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_issue) w_next = CALC;
            CALC: if (kill) w_next = IDLE;
                  else if (r_cnt == '1) w_next = FIX;
            FIX:  w_next = kill ? IDLE : DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_f3    <= '0;
            r_rd    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
            r_rs1   <= '0;
            r_wdata <= '0;
            r_neg   <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_cnt   <= '0;
                r_f3    <= funct3;
                r_rd    <= rd_in;
                r_hi    <= '0;
                r_lo    <= w_mag_a;
                r_b     <= w_mag_b;
                r_rs1   <= rs1_data;
                r_neg   <= w_sa ^ w_sb;
                r_neg_r <= w_sa;
                r_div0  <= (rs2_data == '0);
                r_ovf   <= funct3[2] && !funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                           && (rs2_data == '1);
            end else if (r_state == CALC) begin
                r_cnt <= r_cnt + 1'b1;
                if (!r_f3[2]) begin
                    r_hi <= w_sum[XLEN:1];
                    r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                end else begin
                    r_hi <= w_ge ? w_sub : w_shift[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], w_ge};
                end
            end else if (r_state == FIX && !kill) begin
                r_wdata <= w_result;
            end
        end
    end

    assign busy  = (r_state != IDLE);
    assign done  = (r_state == DONE) && !kill;
    assign rf_en = done && (r_rd != 5'd0);
    assign waddr = r_rd;
    assign wdata = r_wdata;

endmodule
